// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue for the 6502 core.
// Fetches bytes in order, buffers them and emits whole instructions.
module inst_prefetch_queue #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [7:0]        inst_opcode,
  output logic [7:0]        inst_op1,
  output logic [7:0]        inst_op2,
  output logic [1:0]        inst_len,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef logic [CW-1:0]     cnt_t;
  typedef logic [CW:0]       sum_t;
  typedef logic [IW-1:0]     idx_t;
  typedef logic [IW+1:0]     wide_t;
  typedef logic [ADDR_W-1:0] pc_t;
  typedef enum logic {RUN, DRAIN} state_t;

  localparam pc_t   RST_PC  = pc_t'(RESET_PC);
  localparam sum_t  DEPTH_S = sum_t'(DEPTH);
  localparam wide_t DEPTH_W = wide_t'(DEPTH);

  logic [7:0] q [DEPTH];
  idx_t       head;
  idx_t       tail;
  idx_t       h1;
  idx_t       h2;
  cnt_t       count;
  cnt_t       outstanding;
  cnt_t       drop_cnt;
  pc_t        fetch_pc;
  pc_t        pc_q;
  state_t     state;
  logic       issue;
  logic       wr;
  logic       pop;
  logic [1:0] len;

  // Queue index advance that wraps for any DEPTH, not just powers of two
  function automatic idx_t wrap_add(input idx_t a, input logic [1:0] n);
    wide_t s;
    s = {2'b00, a} + {{IW{1'b0}}, n};
    if (s >= DEPTH_W) s = s - DEPTH_W;
    return s[IW-1:0];
  endfunction

  // Opcode aaabbbcc to instruction length; cc=11 is an illegal NOP
  function automatic logic [1:0] len_of(input logic [7:0] op);
    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;
    logic [1:0] l;
    aaa = op[7:5];
    bbb = op[4:2];
    cc  = op[1:0];
    l   = 2'd2;
    unique case (cc)
      2'b01: begin
        if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) l = 2'd3;
      end
      2'b00, 2'b10: begin
        if (bbb[1:0] == 2'b11) l = 2'd3;
        else if (bbb[1:0] == 2'b10) l = 2'd1;
        else if (cc == 2'b00 && bbb == 3'b000 &&
                 (aaa == 3'd0 || aaa == 3'd2 || aaa == 3'd3)) l = 2'd1;
      end
      2'b11: l = 2'd1;
    endcase
    if (op == 8'h20) l = 2'd3;
    return l;
  endfunction

  // Control state follows the drop counter: stale reads block issue
  always_comb begin
    state = (drop_cnt == '0) ? RUN : DRAIN;
  end

  // Request issue and response acceptance
  always_comb begin
    mem_addr = fetch_pc;
    mem_req  = fetch_en && !redirect_valid && (state == RUN) &&
               (({1'b0, count} + {1'b0, outstanding}) < DEPTH_S);
    issue    = mem_req && mem_gnt;
    wr       = mem_rvalid && (state == RUN) && !redirect_valid;
  end

  // Head instruction decode and presentation
  always_comb begin
    len         = len_of(q[head]);
    h1          = wrap_add(head, 2'd1);
    h2          = wrap_add(head, 2'd2);
    inst_opcode = q[head];
    inst_op1    = (len >= 2'd2) ? q[h1] : 8'h00;
    inst_op2    = (len == 2'd3) ? q[h2] : 8'h00;
    inst_len    = len;
    inst_pc     = pc_q;
    inst_valid  = (count != '0) && (count >= cnt_t'(len));
    pop         = inst_valid && inst_ready;
  end

  // Byte storage written at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) q[i] <= 8'h00;
    end else if (wr) begin
      q[tail] <= mem_rdata;
    end
  end

  // Pointers, counters and PCs; redirect overrides everything else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_pc    <= RST_PC;
      pc_q        <= RST_PC;
    end else if (redirect_valid) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      fetch_pc    <= redirect_pc;
      pc_q        <= redirect_pc;
      outstanding <= outstanding + cnt_t'(issue) - cnt_t'(mem_rvalid);
      drop_cnt    <= outstanding + cnt_t'(issue) - cnt_t'(mem_rvalid);
    end else begin
      if (issue) fetch_pc <= fetch_pc + pc_t'(1);
      outstanding <= outstanding + cnt_t'(issue) - cnt_t'(mem_rvalid);
      if (mem_rvalid && state == DRAIN) drop_cnt <= drop_cnt - cnt_t'(1);
      if (wr) tail <= wrap_add(tail, 2'd1);
      if (pop) begin
        head <= wrap_add(head, len);
        pc_q <= pc_q + pc_t'(len);
      end
      count <= count + cnt_t'(wr) - (pop ? cnt_t'(len) : '0);
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: memory model, instruction scoreboard.
// Directed streams cover wrap, backpressure, redirects and opcode lengths.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [7:0]  inst_opcode;
  logic [7:0]  inst_op1;
  logic [7:0]  inst_op2;
  logic [1:0]  inst_len;
  logic [15:0] inst_pc;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [1:0]  len;
    logic [7:0]  op;
    logic [7:0]  o1;
    logic [7:0]  o2;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    int         due;
  } rsp_t;

  exp_t       exp_q [$];
  exp_t       e;
  rsp_t       pend [$];
  logic [7:0] mem [65536];

  inst_prefetch_queue #(
    .ADDR_W   (16),
    .DEPTH    (4),
    .RESET_PC (32'h0000_FFFC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_opcode    (inst_opcode),
    .inst_op1       (inst_op1),
    .inst_op2       (inst_op2),
    .inst_len       (inst_len),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  // In-order memory with programmable latency, reset with the core
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      mem_rvalid <= 1'b0;
      mem_rdata  <= 8'h00;
    end else begin
      if (mem_req && mem_gnt) pend.push_back('{mem[mem_addr], cyc + lat});
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= pend[0].d;
        void'(pend.pop_front());
      end else begin
        mem_rvalid <= 1'b0;
      end
      cyc <= cyc + 1;
    end
  end

  // Scoreboard monitor: every accepted instruction is compared
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_inst: got pc=%h op=%h, none expected",
                 inst_pc, inst_opcode);
      end else begin
        e = exp_q.pop_front();
        if ({inst_pc, inst_len, inst_opcode, inst_op1, inst_op2} !== e) begin
          errors++;
          $display("FAIL inst: got pc=%h len=%0d op=%h %h %h, expected pc=%h len=%0d op=%h %h %h",
                   inst_pc, inst_len, inst_opcode, inst_op1, inst_op2,
                   e.pc, e.len, e.op, e.o1, e.o2);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Nibble view of the 6502 length map
  function automatic logic [1:0] ref_len(input logic [7:0] op);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = op[7:4];
    lo = op[3:0];
    case (lo)
      4'h0: begin
        if (hi == 4'h2) return 2'd3;
        if (hi == 4'h0 || hi == 4'h4 || hi == 4'h6) return 2'd1;
        return 2'd2;
      end
      4'h3, 4'h7, 4'hB, 4'hF, 4'h8, 4'hA: return 2'd1;
      4'h9: return hi[0] ? 2'd3 : 2'd2;
      4'hC, 4'hD, 4'hE: return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [15:0] pc, input logic [1:0] len,
                     input logic [7:0] op, input logic [7:0] o1,
                     input logic [7:0] o2);
    exp_q.push_back('{pc, len, op, o1, o2});
  endtask

  task automatic redirect_to(input logic [15:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic flush_to(input logic [15:0] pc);
    fetch_en = 1'b0;
    redirect_to(pc);
    step(8);
  endtask

  task automatic drain(input string name, input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    inst_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d instructions still expected, expected 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [15:0] pc;
    logic [1:0]  l;

    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'hA9; mem[16'hFFFD] = 8'h05;
    mem[16'hFFFE] = 8'h8D; mem[16'hFFFF] = 8'h00;
    mem[16'h0000] = 8'h02; mem[16'h0001] = 8'hEA;
    mem[16'h0100] = 8'hA9; mem[16'h0101] = 8'h11;
    mem[16'h0102] = 8'hA9; mem[16'h0103] = 8'h22;
    mem[16'h0104] = 8'h4C; mem[16'h0105] = 8'h34;
    mem[16'h0106] = 8'h12;
    mem[16'h0300] = 8'hA2; mem[16'h0301] = 8'h7F;
    mem[16'h0302] = 8'h20; mem[16'h0303] = 8'h00;
    mem[16'h0304] = 8'h04;
    mem[16'h0600] = 8'h0A; mem[16'h0601] = 8'hB1;
    mem[16'h0602] = 8'h40;
    mem[16'h0700] = 8'hA9; mem[16'h0701] = 8'h01;
    mem[16'h0702] = 8'hA9; mem[16'h0703] = 8'h02;
    mem[16'h0704] = 8'hA9; mem[16'h0705] = 8'h03;
    for (int i = 0; i < 256; i++) mem[16'h1000 + 16'(3 * i)] = 8'(i);

    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    mem_gnt        = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;

    // Reset state
    #12;
    chk("rst_req", mem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc", inst_pc, 16'hFFFC);
    chk("rst_addr", mem_addr, 16'hFFFC);

    // Stream across the address wrap
    put(16'hFFFC, 2'd2, 8'hA9, 8'h05, 8'h00);
    put(16'hFFFE, 2'd3, 8'h8D, 8'h00, 8'h02);
    put(16'h0001, 2'd1, 8'hEA, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    fetch_en = 1'b1;
    drain("t1", 100);

    // Backpressure: queue fills, fields hold, no requests
    redirect_to(16'h0100);
    step(10);
    for (int i = 0; i < 3; i++) begin
      chk("t2_req", mem_req, 0);
      chk("t2_addr", mem_addr, 16'h0104);
      chk("t2_valid", inst_valid, 1);
      chk("t2_pc", inst_pc, 16'h0100);
      chk("t2_op", inst_opcode, 8'hA9);
      chk("t2_op1", inst_op1, 8'h11);
      chk("t2_op2", inst_op2, 8'h00);
      chk("t2_len", inst_len, 2'd2);
      step();
    end
    put(16'h0100, 2'd2, 8'hA9, 8'h11, 8'h00);
    put(16'h0102, 2'd2, 8'hA9, 8'h22, 8'h00);
    put(16'h0104, 2'd3, 8'h4C, 8'h34, 8'h12);
    inst_ready = 1'b1;
    drain("t2", 100);

    // Redirect with three reads in flight at latency 3
    flush_to(16'h0200);
    lat      = 3;
    fetch_en = 1'b1;
    #1;
    chk("t3_start_req", mem_req, 1);
    chk("t3_start_addr", mem_addr, 16'h0200);
    step(3);
    chk("t3_addr", mem_addr, 16'h0203);
    redirect_pc    = 16'h0300;
    redirect_valid = 1'b1;
    #1;
    chk("t3_req_masked", mem_req, 0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t3_flushed", inst_valid, 0);
    chk("t3_drain_req0", mem_req, 0);
    step();
    chk("t3_drain_req1", mem_req, 0);
    step();
    chk("t3_resume_req", mem_req, 1);
    chk("t3_resume_addr", mem_addr, 16'h0300);
    put(16'h0300, 2'd2, 8'hA2, 8'h7F, 8'h00);
    put(16'h0302, 2'd3, 8'h20, 8'h00, 8'h04);
    inst_ready = 1'b1;
    drain("t3", 100);

    // Redirect coinciding with a pop and a response
    flush_to(16'h0500);
    lat      = 2;
    fetch_en = 1'b1;
    step(3);
    redirect_pc    = 16'h0600;
    redirect_valid = 1'b1;
    inst_ready     = 1'b1;
    #1;
    chk("t4_pre_valid", inst_valid, 1);
    step();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    #1;
    chk("t4_valid", inst_valid, 0);
    chk("t4_pc", inst_pc, 16'h0600);
    chk("t4_drop_req", mem_req, 0);
    step();
    chk("t4_req", mem_req, 1);
    chk("t4_addr", mem_addr, 16'h0600);
    put(16'h0600, 2'd1, 8'h0A, 8'h00, 8'h00);
    put(16'h0601, 2'd2, 8'hB1, 8'h40, 8'h00);
    inst_ready = 1'b1;
    drain("t4", 100);

    // Opcode length sweep with two EA fillers per opcode
    flush_to(16'h1000);
    lat = 1;
    for (int i = 0; i < 256; i++) begin
      pc = 16'h1000 + 16'(3 * i);
      l  = ref_len(8'(i));
      put(pc, l, 8'(i), (l >= 2'd2) ? 8'hEA : 8'h00,
          (l == 2'd3) ? 8'hEA : 8'h00);
      for (int k = int'(l); k < 3; k++) put(pc + 16'(k), 2'd1, 8'hEA, 8'h00, 8'h00);
    end
    inst_ready = 1'b1;
    fetch_en   = 1'b1;
    drain("t5", 4000);

    // fetch_en pause: in-flight bytes still delivered
    flush_to(16'h0700);
    lat = 3;
    put(16'h0700, 2'd2, 8'hA9, 8'h01, 8'h00);
    put(16'h0702, 2'd2, 8'hA9, 8'h02, 8'h00);
    put(16'h0704, 2'd2, 8'hA9, 8'h03, 8'h00);
    inst_ready = 1'b1;
    fetch_en   = 1'b1;
    step(2);
    fetch_en = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("t6_no_req", mem_req, 0);
      chk("t6_addr", mem_addr, 16'h0702);
      step();
    end
    chk("t6_pc", inst_pc, 16'h0702);
    chk("t6_valid", inst_valid, 0);
    fetch_en = 1'b1;
    #1;
    chk("t6_resume_req", mem_req, 1);
    chk("t6_resume_addr", mem_addr, 16'h0702);
    drain("t6", 100);

    // Asynchronous reset mid-operation
    step(12);
    chk("rst2_pre_valid", inst_valid, 1);
    rst_n    = 1'b0;
    fetch_en = 1'b0;
    #1;
    chk("rst2_valid", inst_valid, 0);
    chk("rst2_req", mem_req, 0);
    chk("rst2_pc", inst_pc, 16'hFFFC);
    chk("rst2_addr", mem_addr, 16'hFFFC);
    chk("leftover", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Parametrised instruction fetch front end for the 6502 core.
- Issues sequential byte reads to memory and buffers the returned bytes in a DEPTH-entry byte queue.
- Determines each instruction's length (1-3 bytes) from its opcode and presents complete instructions (opcode, operands, PC) to the prime decoder over a valid/ready handshake.
- Supports branch/jump redirect with flush and discard of in-flight reads.

Parameters:
- ADDR_W, 16, fetch/PC address width.
- DEPTH, 4, byte queue entries; legal range 3..16.
- RESET_PC, 16'h0000, fetch and instruction PC after reset; truncated to ADDR_W.

Ports:
- clk, input, 1, core clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- fetch_en, input, 1, permits new memory requests; does not affect in-flight reads.
- mem_req, output, 1, byte read request.
- mem_addr, output, ADDR_W, read address.
- mem_gnt, input, 1, request accepted this cycle when mem_req=1.
- mem_rvalid, input, 1, read data valid; responses return in order, at most one per cycle, with latency ≥1.
- mem_rdata, input, 8, read data byte.
- redirect_valid, input, 1, branch/jump taken.
- redirect_pc, input, ADDR_W, new PC.
- inst_valid, output, 1, complete instruction at queue head.
- inst_ready, input, 1, decoder accepts.
- inst_opcode, output, 8, head byte.
- inst_op1, output, 8, head+1 byte; 0 if inst_len<2.
- inst_op2, output, 8, head+2 byte; 0 if inst_len<3.
- inst_len, output, 2, length of head instruction.
- inst_pc, output, ADDR_W, address of the opcode.

Behaviour:

Reset:
- fetch_pc=inst_pc=RESET_PC.
- count=0, outstanding=0, drop_cnt=0.
- mem_req=0, inst_valid=0.

Request issue:
- mem_req=1 iff all hold: fetch_en=1, redirect_valid=0, drop_cnt=0, and count+outstanding<DEPTH.
- mem_addr=fetch_pc.
- On mem_req&&mem_gnt: fetch_pc+=1 (wraps mod 2^ADDR_W), outstanding+=1.

Response:
- On mem_rvalid with drop_cnt>0: byte discarded, drop_cnt-=1.
- On mem_rvalid with drop_cnt=0: byte written at tail, count+=1.
- In both cases outstanding-=1.

Length rule (opcode aaabbbcc):
- 0x20 (JSR) → 3.
- cc=01: bbb∈{011,110,111} → 3; all others → 2.
- cc=10: bbb∈{011,111} → 3; bbb∈{010,110} → 1; all others → 2.
- cc=00: bbb∈{011,111} → 3; bbb∈{010,110} → 1; bbb=000 with aaa∈{000,010,011} → 1; all other bbb=000 → 2; bbb∈{001,100,101} → 2.
- cc=11 → 1 (illegal opcode, treated as NOP).

Output handshake:
- inst_valid = (count ≥ inst_len), decoded combinationally from the head byte; 0 when count=0.
- Instruction fields are stable while inst_valid=1 and inst_ready=0.
- Pop on inst_valid&&inst_ready: head advances by inst_len (queue index wraps mod DEPTH), count-=inst_len, inst_pc+=inst_len (wraps mod 2^ADDR_W).
- A pop and a response write in the same cycle are both applied: count = count − inst_len + 1.

Redirect (highest priority):
- On redirect_valid=1: queue cleared (count=0), fetch_pc=inst_pc=redirect_pc.
- drop_cnt = outstanding + (mem_req&&mem_gnt ? 1 : 0) − (mem_rvalid ? 1 : 0). The request term is always 0, because mem_req is masked during redirect.
- Any pop in that cycle is ignored. inst_valid remains combinational on the pre-flush state, but the decoder must not act on it in the redirect cycle.
- Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.

Counters:
- count, outstanding and drop_cnt are sized for the range 0..DEPTH.
- Invariant: count+outstanding ≤ DEPTH.

State machine (derived from the counters):
- RUN: drop_cnt=0.
- DRAIN: drop_cnt>0; no requests issued.
- Returns to RUN on the cycle drop_cnt reaches 0.

fetch_en=0:
- Stops new requests only.
- Queue and in-flight reads complete normally.

Reset mid-operation:
- All state returns to reset values immediately.
- Responses arriving after reset release are not tracked by this block; the memory side is reset together with the core.

Test Plan:
1. Reset with RESET_PC=16'hFFFC, memory holding A9 05 (LDA #), 8D 00 02 (STA abs), EA, 1-cycle latency, inst_ready=1 → instructions delivered as: len2 pc=FFFC op1=05; len3 pc=FFFE op1=00 op2=02 (address wrap); len1 pc=0001.
2. inst_ready=0 with DEPTH=4 → mem_req drops once count=4; outputs hold stable; no request issued while count+outstanding=4.
3. Memory latency 3 with 3 reads outstanding, redirect to 16'h0300 → the 3 stale bytes are dropped, mem_req stays low until drop_cnt=0, then mem_addr=0300 and the first instruction's inst_pc=0300.
4. Redirect in the same cycle as a pop and a valid response → count=0, no pop applied, drop_cnt=outstanding−1.
5. Opcode sweep 00..FF, each followed by two filler bytes → inst_len matches the length rule for every opcode (e.g. 00→1, 20→3, 4C→3, 0A→1, A2→2, B1→2, 03→1).
6. fetch_en deasserted mid-stream → in-flight bytes still queued and delivered; no new mem_req; fetch resumes at the correct fetch_pc when fetch_en returns to 1.
